// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding, reset PC and instruction field positions for the fetch unit
package ifu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
endpackage

// File: rtl/ifu_next_pc.sv
// ifu_next_pc: next fetch address select among hold, sequential step, redirect target and pending target
module ifu_next_pc #(
    parameter int PC_STEP = 4
) (
    input  logic [31:0] pc,
    input  logic        advance,
    input  logic        take_target,
    input  logic [31:0] target,
    input  logic        take_pend,
    input  logic [31:0] pend_target,
    output logic [31:0] next_pc
);
    always_comb next_pc = take_target ? target : !advance ? pc : take_pend ? pend_target : pc + 32'(PC_STEP);
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC, handshaked imem port and one-entry output register toward decode
// IFU_DELAY_SLOT_EN: when defined, redirects honour a MIPS branch delay slot instead of squashing
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);
    state_t      state;
    logic [31:0] pc, next_pc, target, pend_target;
    logic        kill, pend_valid, rsp, capture, req_fire, take_target, drop;

    assign target   = redirect_target & ~32'h3;
    assign rsp      = state == WAIT && imem_rsp_valid;
    assign req_fire = imem_req_valid && imem_req_ready;
`ifdef IFU_DELAY_SLOT_EN
    assign capture     = rsp && !kill;
    assign take_target = redirect_valid && (instr_valid || capture);
    assign drop        = 1'b0;
`else
    assign capture     = rsp && !kill && !redirect_valid;
    assign take_target = redirect_valid;
    assign drop        = redirect_valid;
`endif
    // a request is only offered when its response is guaranteed an empty output register
    assign imem_req_valid = state == REQ && (!instr_valid || instr_ready);
    assign imem_addr      = pc;
    assign opcode         = instr[OPCODE_MSB:OPCODE_LSB];
    assign func           = instr[FUNC_MSB:FUNC_LSB];

    ifu_next_pc #(.PC_STEP(PC_STEP)) u_next_pc (
        .pc          (pc),
        .advance     (capture),
        .take_target (take_target),
        .target      (target),
        .take_pend   (pend_valid),
        .pend_target (pend_target),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            kill        <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            pc          <= next_pc;
            instr_valid <= capture || (instr_valid && !instr_ready && !drop);
            if (capture) begin
                instr    <= imem_rsp_data;
                instr_pc <= pc;
            end
            case (state)
                IDLE:    state <= REQ;
                REQ:     state <= req_fire ? WAIT : REQ;
                WAIT:    state <= rsp ? REQ : WAIT;
                default: state <= IDLE;
            endcase
`ifdef IFU_DELAY_SLOT_EN
            if (redirect_valid) begin
                pend_valid  <= !(instr_valid || capture);
                pend_target <= target;
            end else if (capture) begin
                pend_valid <= 1'b0;
            end
`else
            kill <= redirect_valid ? (state == WAIT && !imem_rsp_valid) || req_fire : kill && !rsp;
`endif
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed vectors and hand-written redirect/stall/wrap/reset sequences for ifu_fetch
module tb_ifu_fetch;
`ifdef IFU_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc;
    logic [5:0]  opcode, func;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;

    ifu_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .opcode          (opcode),
        .func            (func),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic        mr;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] ins;
        logic [5:0]  op;
        logic [5:0]  fn;
    } vec_t;
    vec_t vecs [10];

    int n_chk = 0, n_fail = 0;
    int lat = 1, mem_cnt = 0, x3008 = 0;
    logic [31:0] mem_a = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h3000 ? 32'h0000_0021 : a == 32'h3004 ? 32'h3421_0005 : a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // one clock: sample handshakes before the edge, then advance the memory model after it
    task automatic cycle();
        bit acc;
        #1;
        acc = rst_n && imem_req_valid && imem_req_ready;
        if (acc) mem_a = imem_addr;
        if (rst_n && instr_valid && instr_ready && instr_pc == 32'h3008) x3008++;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        if (!rst_n) mem_cnt = 0;
        else begin
            if (acc) mem_cnt = lat;
            if (mem_cnt != 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_a);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0,    32'h0,          6'h00, 6'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h3000, 1'b0, 32'h0,    32'h0,          6'h00, 6'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h3004, 1'b1, 32'h3000, 32'h0000_0021,  6'h00, 6'h21};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h3004, 1'b0, 32'h3000, 32'h0000_0021,  6'h00, 6'h21};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h3008, 1'b1, 32'h3004, 32'h3421_0005,  6'h0D, 6'h05};
        for (int i = 5; i < 10; i++) vecs[i] = vecs[4];

        cycle();
        cycle();
        chk("reset.req_valid", imem_req_valid, 0);
        chk("reset.instr_valid", instr_valid, 0);
        chk("reset.instr", instr, 0);
        chk("reset.instr_pc", instr_pc, 0);
        chk("reset.addr", imem_addr, 32'h3000);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            instr_ready    = vecs[i].ir;
            imem_req_ready = vecs[i].mr;
            cycle();
            chk($sformatf("vec%0d.req_valid", i), imem_req_valid, vecs[i].rv);
            chk($sformatf("vec%0d.addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("vec%0d.instr_valid", i), instr_valid, vecs[i].iv);
            chk($sformatf("vec%0d.instr_pc", i), instr_pc, vecs[i].ipc);
            chk($sformatf("vec%0d.instr", i), instr, vecs[i].ins);
            chk($sformatf("vec%0d.opcode", i), opcode, vecs[i].op);
            chk($sformatf("vec%0d.func", i), func, vecs[i].fn);
        end

        instr_ready = 1'b1;
        cycle();
        cycle();
        chk("hold.instr_pc", instr_pc, 32'h3008);
        chk("hold.instr_valid", instr_valid, 1);
        instr_ready     = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h3200;
        cycle();
        chk("redir_hold.instr_valid", instr_valid, DS);
        chk("redir_hold.addr", imem_addr, 32'h3200);
        chk("redir_hold.req_valid", imem_req_valid, !DS);
        instr_ready = 1'b1;
        cycle();
        chk("redir_hold.next_empty", instr_valid, 0);
        cycle();
        chk("redir_hold.tgt_pc", instr_pc, 32'h3200);
        chk("redir_hold.tgt_valid", instr_valid, 1);
        chk("redir_hold.x3008", x3008, DS);

        lat = 3;
        cycle();
        redirect_valid  = 1'b1;
        redirect_target = 32'h3100;
        cycle();
        chk("redir_wait.addr", imem_addr, DS ? 32'h3204 : 32'h3100);
        cycle();
        chk("redir_wait.empty", instr_valid, 0);
        cycle();
        chk("redir_wait.stale", instr_valid, DS);
        chk("redir_wait.next_addr", imem_addr, 32'h3100);
        chk("redir_wait.req_valid", imem_req_valid, 1);
        lat = 1;
        cycle();
        cycle();
        chk("redir_wait.tgt_pc", instr_pc, 32'h3100);
        chk("redir_wait.tgt_instr", instr, mem_word(32'h3100));
        chk("redir_wait.tgt_valid", instr_valid, 1);

        imem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("stall%0d.req_valid", k), imem_req_valid, 1);
            chk($sformatf("stall%0d.addr", k), imem_addr, 32'h3104);
        end
        imem_req_ready = 1'b1;
        cycle();
        cycle();
        chk("stall.instr_pc", instr_pc, 32'h3104);

        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        cycle();
        chk("wrap.tgt_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap.instr_valid", instr_valid, 0);
        imem_req_ready = 1'b1;
        cycle();
        cycle();
        chk("wrap.instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap.next_addr", imem_addr, 32'h0);

        lat = 3;
        cycle();
        chk("rst_wait.req_valid", imem_req_valid, 0);
        rst_n = 1'b0;
        cycle();
        chk("rst_wait.req_valid_r", imem_req_valid, 0);
        chk("rst_wait.instr_valid", instr_valid, 0);
        chk("rst_wait.instr", instr, 0);
        chk("rst_wait.instr_pc", instr_pc, 0);
        chk("rst_wait.addr", imem_addr, 32'h3000);
        rst_n = 1'b1;
        lat   = 1;
        cycle();
        cycle();
        cycle();
        chk("rst_wait.refetch_pc", instr_pc, 32'h3000);
        chk("rst_wait.refetch_instr", instr, 32'h0000_0021);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
